// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: load-use bubble, branch flush, mul/div EX occupancy, SYSCALL halt.
// All outputs are combinational, so a stall acts in its detection cycle; only the mode and mul/div counter are registered.
module hazard_ctrl #(
   parameter int MUL_LAT = 2,
   parameter int DIV_LAT = 8
) (
   input  logic       clk,
   input  logic       CLR,
   input  logic [4:0] ID_rs,
   input  logic [4:0] ID_rt,
   input  logic       ID_rs_used,
   input  logic       ID_rt_used,
   input  logic       EX_valid,
   input  logic       EX_MemtoReg,
   input  logic       EX_RegWrite,
   input  logic [4:0] EX_WbRegNum,
   input  logic       EX_bj_taken,
   input  logic       EX_mul,
   input  logic       EX_div,
   input  logic       WB_halt,
   input  logic       go,
   output logic       PC_EN,
   output logic       IFID_EN,
   output logic       IDEX_EN,
   output logic       EXMEM_EN,
   output logic       MEMWB_EN,
   output logic       bb_data,
   output logic       bb_bj,
   output logic       EXMEM_bb,
   output logic       md_busy,
   output logic       halted
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CW      = ($clog2(MAX_LAT) < 1) ? 1 : $clog2(MAX_LAT);

   localparam logic [CW-1:0] MUL_LOAD = CW'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
   localparam logic [CW-1:0] DIV_LOAD = CW'((DIV_LAT > 1) ? DIV_LAT - 2 : 0);
   localparam logic          MUL_MULTI = (MUL_LAT > 1);
   localparam logic          DIV_MULTI = (DIV_LAT > 1);

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_MD   = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   logic load_use;
   logic bj_flush;
   logic md_start;
   logic md_hold;

   // A zero destination never creates a dependency: $zero is hard-wired.
   assign load_use = EX_valid && EX_MemtoReg && EX_RegWrite && (EX_WbRegNum != 5'd0) &&
                     ((ID_rs_used && (ID_rs == EX_WbRegNum)) ||
                      (ID_rt_used && (ID_rt == EX_WbRegNum)));

   assign bj_flush = EX_valid && EX_bj_taken;

   // Divide wins when both opcode flags are set; single-cycle units never stall.
   assign md_start = EX_valid && (EX_div ? DIV_MULTI : (EX_mul && MUL_MULTI));

   assign md_hold = ((state == S_RUN) && md_start) || ((state == S_MD) && (cnt != '0));

   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         state <= S_RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_RUN: begin
            if (WB_halt) begin
               state_nxt = S_HALT;
               cnt_nxt   = '0;
            end else if (md_start) begin
               state_nxt = S_MD;
               cnt_nxt   = EX_div ? DIV_LOAD : MUL_LOAD;
            end
         end
         S_MD: begin
            // A halt abandons the in-flight operation so nothing stalls after resume.
            if (WB_halt) begin
               state_nxt = S_HALT;
               cnt_nxt   = '0;
            end else if (cnt != '0) begin
               cnt_nxt = cnt - CW'(1);
            end else begin
               state_nxt = S_RUN;
            end
         end
         S_HALT: begin
            if (go) begin
               state_nxt = S_RUN;
            end
         end
         default: begin
            state_nxt = S_RUN;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      PC_EN    = 1'b1;
      IFID_EN  = 1'b1;
      IDEX_EN  = 1'b1;
      EXMEM_EN = 1'b1;
      MEMWB_EN = 1'b1;
      bb_data  = 1'b0;
      bb_bj    = 1'b0;
      EXMEM_bb = 1'b0;
      md_busy  = 1'b0;
      halted   = 1'b0;
      if (state == S_HALT) begin
         PC_EN    = 1'b0;
         IFID_EN  = 1'b0;
         IDEX_EN  = 1'b0;
         EXMEM_EN = 1'b0;
         MEMWB_EN = 1'b0;
         halted   = 1'b1;
      end else if (WB_halt) begin
         // Let the SYSCALL retire through WB; everything upstream freezes.
         PC_EN    = 1'b0;
         IFID_EN  = 1'b0;
         IDEX_EN  = 1'b0;
         EXMEM_EN = 1'b0;
      end else if (md_hold) begin
         PC_EN    = 1'b0;
         IFID_EN  = 1'b0;
         IDEX_EN  = 1'b0;
         EXMEM_bb = 1'b1;
         md_busy  = 1'b1;
      end else if ((state == S_RUN) && bj_flush) begin
         IFID_EN = 1'b0;
         IDEX_EN = 1'b0;
         bb_bj   = 1'b1;
      end else if ((state == S_RUN) && load_use) begin
         PC_EN   = 1'b0;
         IFID_EN = 1'b0;
         IDEX_EN = 1'b0;
         bb_data = 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed scoreboard bench for hazard_ctrl; two instances cover multi-cycle and single-cycle multiply.
module tb_hazard_ctrl;

   typedef struct packed {
      logic [4:0] id_rs;
      logic [4:0] id_rt;
      logic       id_rs_used;
      logic       id_rt_used;
      logic       ex_valid;
      logic       ex_mem2reg;
      logic       ex_regwrite;
      logic [4:0] ex_wb;
      logic       ex_bj;
      logic       ex_mul;
      logic       ex_div;
      logic       wb_halt;
      logic       go;
   } stim_t;

   typedef struct {
      logic [9:0] exp_a;
      logic [9:0] exp_b;
      int         cyc;
   } exp_t;

   // Output vector order: {PC,IFID,IDEX,EXMEM,MEMWB, bb_data,bb_bj,EXMEM_bb,md_busy,halted}
   localparam logic [9:0] V_DEF    = 10'b11111_00000;
   localparam logic [9:0] V_FREEZE = 10'b00011_00110;
   localparam logic [9:0] V_BJ     = 10'b10011_01000;
   localparam logic [9:0] V_LU     = 10'b00011_10000;
   localparam logic [9:0] V_HDET   = 10'b00001_00000;
   localparam logic [9:0] V_HALT   = 10'b00000_00001;

   localparam int A_MUL = 2, A_DIV = 8;
   localparam int B_MUL = 1, B_DIV = 3;

   logic       clk = 1'b0;
   logic       CLR;
   logic [4:0] ID_rs, ID_rt, EX_WbRegNum;
   logic       ID_rs_used, ID_rt_used, EX_valid, EX_MemtoReg, EX_RegWrite;
   logic       EX_bj_taken, EX_mul, EX_div, WB_halt, go;

   logic pc_a, ifid_a, idex_a, exmem_a, memwb_a, bbd_a, bbj_a, exbb_a, mdb_a, hlt_a;
   logic pc_b, ifid_b, idex_b, exmem_b, memwb_b, bbd_b, bbj_b, exbb_b, mdb_b, hlt_b;
   logic [9:0] out_a, out_b;

   assign out_a = {pc_a, ifid_a, idex_a, exmem_a, memwb_a, bbd_a, bbj_a, exbb_a, mdb_a, hlt_a};
   assign out_b = {pc_b, ifid_b, idex_b, exmem_b, memwb_b, bbd_b, bbj_b, exbb_b, mdb_b, hlt_b};

   always #5 clk = ~clk;

   hazard_ctrl #(.MUL_LAT(A_MUL), .DIV_LAT(A_DIV)) u_dut_a (
      .clk(clk), .CLR(CLR), .ID_rs(ID_rs), .ID_rt(ID_rt),
      .ID_rs_used(ID_rs_used), .ID_rt_used(ID_rt_used), .EX_valid(EX_valid),
      .EX_MemtoReg(EX_MemtoReg), .EX_RegWrite(EX_RegWrite), .EX_WbRegNum(EX_WbRegNum),
      .EX_bj_taken(EX_bj_taken), .EX_mul(EX_mul), .EX_div(EX_div), .WB_halt(WB_halt), .go(go),
      .PC_EN(pc_a), .IFID_EN(ifid_a), .IDEX_EN(idex_a), .EXMEM_EN(exmem_a), .MEMWB_EN(memwb_a),
      .bb_data(bbd_a), .bb_bj(bbj_a), .EXMEM_bb(exbb_a), .md_busy(mdb_a), .halted(hlt_a)
   );

   hazard_ctrl #(.MUL_LAT(B_MUL), .DIV_LAT(B_DIV)) u_dut_b (
      .clk(clk), .CLR(CLR), .ID_rs(ID_rs), .ID_rt(ID_rt),
      .ID_rs_used(ID_rs_used), .ID_rt_used(ID_rt_used), .EX_valid(EX_valid),
      .EX_MemtoReg(EX_MemtoReg), .EX_RegWrite(EX_RegWrite), .EX_WbRegNum(EX_WbRegNum),
      .EX_bj_taken(EX_bj_taken), .EX_mul(EX_mul), .EX_div(EX_div), .WB_halt(WB_halt), .go(go),
      .PC_EN(pc_b), .IFID_EN(ifid_b), .IDEX_EN(idex_b), .EXMEM_EN(exmem_b), .MEMWB_EN(memwb_b),
      .bb_data(bbd_b), .bb_bj(bbj_b), .EXMEM_bb(exbb_b), .md_busy(mdb_b), .halted(hlt_b)
   );

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   drv_done = 1'b0;

   // Reference model: "halted" flag plus the number of EX cycles the current mul/div still owns.
   bit m_halt_a, m_halt_b;
   int m_left_a, m_left_b;

   task automatic model_step(input int lm, input int ld, input stim_t s,
                             input bit h_in, input int left_in,
                             output logic [9:0] v, output bit h_out, output int left_out);
      bit lu;
      int lat;
      v        = V_DEF;
      h_out    = h_in;
      left_out = left_in;
      lu = s.ex_valid && s.ex_mem2reg && s.ex_regwrite && (s.ex_wb != 0) &&
           ((s.id_rs_used && s.id_rs == s.ex_wb) || (s.id_rt_used && s.id_rt == s.ex_wb));
      lat = s.ex_div ? ld : lm;
      if (h_in) begin
         v = V_HALT;
         if (s.go) h_out = 1'b0;
      end else if (s.wb_halt) begin
         v        = V_HDET;
         h_out    = 1'b1;
         left_out = 0;
      end else if (left_in > 1) begin
         v        = V_FREEZE;
         left_out = left_in - 1;
      end else if (left_in == 1) begin
         left_out = 0;
      end else if (s.ex_valid && (s.ex_mul || s.ex_div) && lat > 1) begin
         v        = V_FREEZE;
         left_out = lat - 1;
      end else if (s.ex_valid && s.ex_bj) begin
         v = V_BJ;
      end else if (lu) begin
         v = V_LU;
      end
   endtask

   // clr_mode: 0 none, 1 assert CLR mid-cycle, 2 hold CLR for the whole cycle.
   task automatic apply(input stim_t s, input int clr_mode);
      exp_t e;
      bit   h;
      int   l;
      @(posedge clk);
      #1;
      CLR         = (clr_mode == 2);
      ID_rs       = s.id_rs;
      ID_rt       = s.id_rt;
      ID_rs_used  = s.id_rs_used;
      ID_rt_used  = s.id_rt_used;
      EX_valid    = s.ex_valid;
      EX_MemtoReg = s.ex_mem2reg;
      EX_RegWrite = s.ex_regwrite;
      EX_WbRegNum = s.ex_wb;
      EX_bj_taken = s.ex_bj;
      EX_mul      = s.ex_mul;
      EX_div      = s.ex_div;
      WB_halt     = s.wb_halt;
      go          = s.go;
      if (clr_mode == 1) begin
         #2;
         CLR = 1'b1;
      end
      if (clr_mode != 0) begin
         m_halt_a = 0; m_left_a = 0;
         m_halt_b = 0; m_left_b = 0;
      end
      model_step(A_MUL, A_DIV, s, m_halt_a, m_left_a, e.exp_a, h, l);
      m_halt_a = h; m_left_a = l;
      model_step(B_MUL, B_DIV, s, m_halt_b, m_left_b, e.exp_b, h, l);
      m_halt_b = h; m_left_b = l;
      if (clr_mode != 0) begin
         m_halt_a = 0; m_left_a = 0;
         m_halt_b = 0; m_left_b = 0;
      end
      e.cyc = cyc;
      sb.push_back(e);
      cyc++;
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s.id_rs       = 5'($urandom_range(0, 3));
      s.id_rt       = 5'($urandom_range(0, 3));
      s.id_rs_used  = 1'($urandom_range(0, 1));
      s.id_rt_used  = 1'($urandom_range(0, 1));
      s.ex_valid    = ($urandom_range(0, 3) != 0);
      s.ex_mem2reg  = 1'($urandom_range(0, 1));
      s.ex_regwrite = ($urandom_range(0, 3) != 0);
      s.ex_wb       = 5'($urandom_range(0, 3));
      s.ex_bj       = ($urandom_range(0, 6) == 0);
      s.ex_mul      = ($urandom_range(0, 9) == 0);
      s.ex_div      = ($urandom_range(0, 11) == 0);
      s.wb_halt     = ($urandom_range(0, 49) == 0);
      s.go          = ($urandom_range(0, 5) == 0);
      return s;
   endfunction

   // Monitor: the controller presents a fresh decision every cycle, sampled mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (out_a !== e.exp_a) begin
               errors++;
               $display("FAIL outs_a cyc %0d got %b want %b", e.cyc, out_a, e.exp_a);
            end
            checks++;
            if (out_b !== e.exp_b) begin
               errors++;
               $display("FAIL outs_b cyc %0d got %b want %b", e.cyc, out_b, e.exp_b);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog cyc %0d got no completion want completion", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      stim_t s;
      CLR = 1'b1;
      ID_rs = '0; ID_rt = '0; EX_WbRegNum = '0;
      ID_rs_used = 0; ID_rt_used = 0; EX_valid = 0; EX_MemtoReg = 0; EX_RegWrite = 0;
      EX_bj_taken = 0; EX_mul = 0; EX_div = 0; WB_halt = 0; go = 0;
      m_halt_a = 0; m_left_a = 0; m_halt_b = 0; m_left_b = 0;

      apply(idle(), 2);
      apply(idle(), 2);
      apply(idle(), 0);

      // load-use on rs, then with $zero destination
      s = idle();
      s.ex_valid = 1; s.ex_mem2reg = 1; s.ex_regwrite = 1; s.ex_wb = 5'd8;
      s.id_rs = 5'd8; s.id_rs_used = 1;
      apply(s, 0);
      apply(idle(), 0);
      s.ex_wb = 5'd0; s.id_rs = 5'd0;
      apply(s, 0);
      // load-use on rt only
      s.ex_wb = 5'd9; s.id_rs = 5'd3; s.id_rt = 5'd9; s.id_rt_used = 1;
      apply(s, 0);

      // taken branch alone, then together with a load-use match
      s = idle();
      s.ex_valid = 1; s.ex_bj = 1;
      apply(s, 0);
      s.ex_mem2reg = 1; s.ex_regwrite = 1; s.ex_wb = 5'd8; s.id_rs = 5'd8; s.id_rs_used = 1;
      apply(s, 0);
      apply(idle(), 0);

      // divide holds EX for its full latency, then multiply
      s = idle();
      s.ex_valid = 1; s.ex_div = 1;
      for (int i = 0; i < A_DIV; i++) apply(s, 0);
      apply(idle(), 0);
      s = idle();
      s.ex_valid = 1; s.ex_mul = 1;
      for (int i = 0; i < A_MUL; i++) apply(s, 0);
      apply(idle(), 0);

      // halt pulse, idle in HALT, resume
      s = idle(); s.wb_halt = 1;
      apply(s, 0);
      for (int i = 0; i < 5; i++) apply(idle(), 0);
      s = idle(); s.go = 1;
      apply(s, 0);
      apply(idle(), 0);

      // halt on the third cycle of a divide, resume with no leftover stall
      s = idle(); s.ex_valid = 1; s.ex_div = 1;
      apply(s, 0);
      apply(s, 0);
      s.wb_halt = 1;
      apply(s, 0);
      apply(idle(), 0);
      s = idle(); s.go = 1;
      apply(s, 0);
      for (int i = 0; i < 3; i++) apply(idle(), 0);

      // asynchronous clear in the middle of a divide
      s = idle(); s.ex_valid = 1; s.ex_div = 1;
      apply(s, 0);
      apply(s, 0);
      apply(idle(), 1);
      s = idle();
      s.ex_valid = 1; s.ex_mem2reg = 1; s.ex_regwrite = 1; s.ex_wb = 5'd5;
      s.id_rt = 5'd5; s.id_rt_used = 1;
      apply(s, 0);

      for (int i = 0; i < 2500; i++) begin
         apply(rand_stim(), ($urandom_range(0, 99) == 0) ? 1 : 0);
      end

      drv_done = 1'b1;
      for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central stall/flush controller for the five-stage MIPS pipeline. Each cycle it drives the enable and bubble inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers (`EN`, `bb_data`, `bb_bj`). It covers four cases: load-use hazards, branch/jump flushes resolved in EX, multi-cycle multiply/divide occupancy of EX, and SYSCALL halt. It holds the only sequential pipeline-control state in the core: a mul/div latency counter and a RUN/MD/HALT state machine.

## Interface
Parameters:
- `MUL_LAT`, default 2: cycles a MULT/MULTU occupies EX; must be ≥1.
- `DIV_LAT`, default 8: cycles a DIV/DIVU occupies EX; must be ≥1.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `CLR`  in  1  reset; asynchronous, active-high.
- `ID_rs`, `ID_rt`  in  5 each  source register numbers of the instruction in ID.
- `ID_rs_used`, `ID_rt_used`  in  1 each  the ID instruction reads rs / rt.
- `EX_valid`  in  1  the ID/EX register's `Out` (EX holds a real instruction).
- `EX_MemtoReg`  in  1  the EX instruction is a load.
- `EX_RegWrite`  in  1  the EX instruction writes a GPR.
- `EX_WbRegNum`  in  5  the EX destination register.
- `EX_bj_taken`  in  1  branch taken or jump in EX.
- `EX_mul`, `EX_div`  in  1 each  the EX instruction is a multiply / divide.
- `WB_halt`  in  1  a SYSCALL exit reaches WB this cycle.
- `go`  in  1  resume pulse out of HALT.
- `PC_EN`, `IFID_EN`, `IDEX_EN`, `EXMEM_EN`, `MEMWB_EN`  out  1 each  register enables.
- `bb_data`  out  1  load-use bubble into ID/EX.
- `bb_bj`  out  1  branch flush of IF/ID and ID/EX.
- `EXMEM_bb`  out  1  bubble into EX/MEM while EX is busy.
- `md_busy`  out  1  EX is occupied by a mul/div.
- `halted`  out  1  core is halted.

## Operation
- States: RUN, MD, HALT.
- Counter: `cnt`, width `$clog2(max(MUL_LAT,DIV_LAT))` (minimum 1 bit).
- All outputs are combinational from the state, `cnt` and the inputs, so a stall takes effect in the cycle it is detected.
- Default outputs (RUN, no hazard): all five enables = 1; `bb_data`, `bb_bj`, `EXMEM_bb`, `md_busy`, `halted` = 0.
- Priority, highest first: HALT, MD occupancy, `bb_bj`, `bb_data`.
- Load-use condition (RUN only): `EX_valid & EX_MemtoReg & EX_RegWrite & EX_WbRegNum!=0` and the destination matches `ID_rs` with `ID_rs_used`, or `ID_rt` with `ID_rt_used`. Response:
  - `PC_EN=0`, `IFID_EN=0`, `IDEX_EN=0`, `bb_data=1`.
  - EX/MEM and MEM/WB stay enabled.
- Branch/jump (RUN, `EX_valid & EX_bj_taken`): `IFID_EN=0`, `IDEX_EN=0`, `bb_bj=1`, `PC_EN=1` so the PC loads the target.
- Mul/div start (RUN, `EX_valid & (EX_mul|EX_div)`, selected latency L):
  - L=1: no effect.
  - L>1: freeze `PC_EN`, `IFID_EN`, `IDEX_EN` = 0; `EXMEM_EN=1` with `EXMEM_bb=1`; `md_busy=1`; load `cnt<=L-2`; state<=MD.
  - `EX_div` wins if both are set.
- MD state:
  - `cnt!=0`: same freeze outputs as the start cycle; `cnt<=cnt-1`.
  - `cnt==0`: default outputs (the result enters EX/MEM); state<=RUN.
  - `EX_mul`, `EX_div`, `EX_bj_taken` and the load-use condition are ignored in MD.
- HALT entry: `WB_halt` in any state. The transition happens at the next edge; in the detection cycle `MEMWB_EN` stays 1 and all other enables are 0.
- HALT state:
  - All enables = 0, `halted=1`, `cnt` held.
  - `go` returns to RUN; `go` is ignored outside HALT.
  - An MD operation interrupted by a halt is abandoned: `cnt` is cleared on HALT entry.
- Reset: state=RUN, `cnt=0`. Outputs therefore take the default values, all enables = 1.

## Timing
- A mul/div occupies EX for exactly L cycles: the RUN start cycle plus L-1 MD cycles. The front end is frozen for L-1 cycles.
- A load-use hazard costs one cycle. The condition clears on the next cycle because the load has moved to MEM.
- A branch flush costs two cycles (the IF/ID and ID/EX contents are discarded).
- HALT is entered one edge after `WB_halt` and exited one edge after `go`. The first cycle after exit uses RUN outputs.
- Asserting `CLR` mid-MD or mid-HALT returns to RUN immediately and asynchronously.

## Test plan
- Load-use: `lw $t0` in EX (`EX_WbRegNum=8`, `EX_MemtoReg=1`), `add` in ID with `ID_rs=8` → one cycle of `PC_EN=IFID_EN=IDEX_EN=0` with `bb_data=1`, then all enables = 1. Repeat with `EX_WbRegNum=0` → no stall.
- Taken `beq` in EX → `bb_bj=1`, `PC_EN=1`, `IFID_EN=IDEX_EN=0` for one cycle. The same cycle with a load-use match → `bb_data=0`.
- `EX_div` with `DIV_LAT=8` → `md_busy=1` for 7 cycles and `EXMEM_bb=1` for 7 cycles; on cycle 8 all enables = 1; next cycle the state is RUN. `EX_mul` with `MUL_LAT=2` → 1 stall cycle. `MUL_LAT=1` → none.
- `WB_halt` pulse → next cycle `halted=1` with all enables = 0. This holds for 5 idle cycles; `go` → RUN the following cycle.
- `WB_halt` on the 3rd cycle of a divide → HALT with `cnt=0`. After `go`, no residual stall.
- `CLR` asserted between clock edges during MD → outputs immediately return to the defaults, and the state is RUN.
